// File: rtl/captura_monto_pkg.sv
// captura_monto_pkg: shared state encoding, keypad codes and the x10 accumulate step
package captura_monto_pkg;
    typedef enum logic [1:0] {IDLE, CAPTURA, ENTREGA} estado_t;
    localparam logic [3:0] TECLA_ENTER  = 4'hA;
    localparam logic [3:0] TECLA_BORRAR = 4'hB;
    localparam logic [3:0] MAX_DIGITOS  = 4'd9;
    localparam logic [3:0] ULTIMO_DIGITO = 4'd9;
    function automatic logic [31:0] por_diez_mas(input logic [31:0] a, input logic [3:0] d);
        return (a << 3) + (a << 1) + {28'd0, d};
    endfunction
endpackage

// File: rtl/detector_flanco.sv
// detector_flanco: one-cycle pulse on a rising edge of in, aligned with the edge cycle
module detector_flanco (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic pulse
);
    logic prev;
    always_ff @(posedge clock or posedge reset)
        if (reset) prev <= 1'b0;
        else prev <= in;
    assign pulse = in & ~prev;
endmodule

// File: rtl/captura_monto.sv
// captura_monto: keypad amount entry for the ATM controller, up to nine decimal digits
module captura_monto
    import captura_monto_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        HABILITAR,
    input  logic [3:0]  TECLA,
    input  logic        TECLA_STB,
    output logic [31:0] MONTO,
    output logic        MONTO_STB,
    output logic        ERROR_MONTO,
    output logic [3:0]  DIGITOS
);
    estado_t     estado;
    logic [31:0] acc;
    logic        evento;
    detector_flanco u_flanco (
        .clock(clock),
        .reset(reset),
        .in   (TECLA_STB),
        .pulse(evento)
    );
    // A stale high strobe at reset release only pulses while still IDLE, where keys are ignored
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado      <= IDLE;
            acc         <= '0;
            DIGITOS     <= '0;
            MONTO       <= '0;
            MONTO_STB   <= 1'b0;
            ERROR_MONTO <= 1'b0;
        end else begin
            MONTO_STB   <= 1'b0;
            ERROR_MONTO <= 1'b0;
            case (estado)
                IDLE: if (HABILITAR) begin
                    estado  <= CAPTURA;
                    acc     <= '0;
                    DIGITOS <= '0;
                end
                CAPTURA: if (!HABILITAR) begin
                    estado  <= IDLE;
                    acc     <= '0;
                    DIGITOS <= '0;
                end else if (evento) begin
                    if (TECLA <= ULTIMO_DIGITO) begin
                        if (DIGITOS < MAX_DIGITOS) begin
                            acc     <= por_diez_mas(acc, TECLA);
                            DIGITOS <= DIGITOS + 4'd1;
                        end else ERROR_MONTO <= 1'b1;
                    end else if (TECLA == TECLA_ENTER) begin
                        if (DIGITOS == 4'd0) ERROR_MONTO <= 1'b1;
                        else begin
                            MONTO     <= acc;
                            MONTO_STB <= 1'b1;
                            estado    <= ENTREGA;
                        end
                    end else if (TECLA == TECLA_BORRAR) begin
                        acc     <= '0;
                        DIGITOS <= '0;
                    end
                end
                ENTREGA: begin
                    estado  <= IDLE;
                    acc     <= '0;
                    DIGITOS <= '0;
                end
                default: estado <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/captura_monto.md
CAPTURA_MONTO -- requirements
Module: captura_monto

Interface
REQ-001 SHALL have port clock, input, 1 bit: single system clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port HABILITAR, input, 1 bit: high while the ATM controller is in its amount-entry phase.
REQ-004 SHALL have port TECLA, input, 4 bits: keypad code; 0-9 are digits, 4'hA is ENTER, 4'hB is BORRAR (clear), all other codes are ignored.
REQ-005 SHALL have port TECLA_STB, input, 1 bit: key-valid strobe, synchronous to clock, may stay high for several cycles.
REQ-006 SHALL have port MONTO, output, 32 bits: binary amount delivered to the controller.
REQ-007 SHALL have port MONTO_STB, output, 1 bit: one-cycle pulse marking MONTO valid.
REQ-008 SHALL have port ERROR_MONTO, output, 1 bit: one-cycle pulse on a rejected key.
REQ-009 SHALL have port DIGITOS, output, 4 bits: count of digits accepted in the current entry, 0-9.

Function
REQ-010 SHALL detect a key event only on a TECLA_STB rising edge (TECLA_STB=1 and previous-cycle TECLA_STB=0), so one held press counts once.
REQ-011 SHALL sample TECLA in the same cycle as the detected edge.
REQ-012 SHALL implement states IDLE, CAPTURA, ENTREGA.
REQ-013 IDLE -> CAPTURA when HABILITAR=1; accumulator and DIGITOS are cleared on entry.
REQ-014 In CAPTURA, a digit key with DIGITOS<9 SHALL set acc = acc*10 + TECLA, computed as (acc<<3)+(acc<<1)+TECLA in 32 bits, and increment DIGITOS.
REQ-015 A digit key with DIGITOS=9 SHALL leave acc unchanged and pulse ERROR_MONTO; the 9-digit limit keeps acc at or below 999_999_999, so no 32-bit overflow can occur.
REQ-016 BORRAR SHALL clear acc and DIGITOS to 0 and SHALL NOT pulse ERROR_MONTO.
REQ-017 ENTER with DIGITOS=0 SHALL pulse ERROR_MONTO and remain in CAPTURA.
REQ-018 ENTER with DIGITOS>0 SHALL load MONTO<=acc and enter ENTREGA.
REQ-019 MONTO_STB SHALL be high exactly one cycle: the cycle after the clock edge that sampled the ENTER event.
REQ-020 ENTREGA -> IDLE unconditionally after one cycle, clearing acc and DIGITOS.
REQ-021 MONTO SHALL hold its last delivered value until the next delivery or reset.
REQ-022 HABILITAR=0 in CAPTURA SHALL discard the entry (acc=0, DIGITOS=0) and return to IDLE with no MONTO_STB; any key edge in that cycle is ignored.
REQ-023 Key edges in IDLE or ENTREGA SHALL be ignored, with no ERROR_MONTO pulse.
REQ-024 Ignored codes 4'hC-4'hF in CAPTURA SHALL have no effect and SHALL NOT pulse ERROR_MONTO.
REQ-025 ERROR_MONTO and MONTO_STB SHALL never be high in the same cycle.

Reset
REQ-026 While reset=1, state SHALL be IDLE and MONTO, MONTO_STB, ERROR_MONTO, DIGITOS, acc and the edge-detect register SHALL all be 0, independent of clock.
REQ-027 Reset asserted mid-entry SHALL abort the entry with no MONTO_STB.
REQ-028 After reset release, a TECLA_STB already high SHALL NOT produce an event until it has been low for at least one cycle.

Structure
REQ-029 A shared package SHALL hold the state encoding, key codes (TECLA_ENTER=4'hA, TECLA_BORRAR=4'hB) and MAX_DIGITOS=9.
REQ-030 Rising-edge detection SHALL be a sub-module, detector_flanco (clock, reset, in, pulse).
REQ-031 The multiply-by-10 SHALL use shifts and adds only, with no multiplier inference.

Verification
REQ-032 HABILITAR=1; keys 5,0,0,0 then ENTER -> MONTO=5000, one MONTO_STB pulse, DIGITOS back to 0.
REQ-033 Keys 1-9 then 7 then ENTER -> ERROR_MONTO pulse on the 10th digit; MONTO=123456789.
REQ-034 ENTER with no digits -> ERROR_MONTO pulse, no MONTO_STB; then 4,2,BORRAR,7,ENTER -> MONTO=7.
REQ-035 TECLA_STB held 5 cycles with TECLA=3, then ENTER -> MONTO=3 (held press counted once).
REQ-036 Keys 8,8 then HABILITAR=0, then HABILITAR=1 and 1,ENTER -> MONTO=1, never 881.
REQ-037 reset pulsed after 2,5 -> all outputs 0 asynchronously; later 9,ENTER -> MONTO=9.
